hier_func_div_21ns_6ns_15_seq: RTL

Sequential radix-2 restoring divider that inverts the 15×6→21 unsigned multiply: it takes a 21-bit unsigned dividend and a 6-bit unsigned divisor and returns a 15-bit quotient and 6-bit remainder. It sits beside the pipelined multiplier inside `hier_func` to recover one factor from a product. Valid/ready handshakes on both sides and a global `ce` stall let the HLS scheduler hold it like the other operator cores.

---
 rtl/hier_func_div_pkg.sv | 26 ++
 rtl/hier_func_div_step.sv | 31 +++
 rtl/hier_func_div_21ns_6ns_15_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hier_func_div_pkg.sv
// ============================================================================
// Module   : hier_func_div_pkg
// Brief    : Shared types and widths for the hier_func sequential divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hier_func_div_pkg;

    localparam int DIV_N_W   = 21;
    localparam int DIV_D_W   = 6;
    localparam int DIV_Q_W   = 15;
    localparam int DIV_CNT_W = 4;

    localparam logic [DIV_Q_W-1:0]   DIV_Q_SAT     = 15'h7FFF;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST_STEP = 4'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/hier_func_div_step.sv
// ============================================================================
// Module   : hier_func_div_step
// Brief    : One combinational restoring-division step (shift, trial subtract).
// Revision : 1.0
// ============================================================================
`default_nettype none

module hier_func_div_step
    import hier_func_div_pkg::*;
(
    input  logic [DIV_D_W:0]   i_rem,
    input  logic               i_bit,
    input  logic [DIV_D_W-1:0] i_divisor,
    output logic [DIV_D_W:0]   o_rem,
    output logic               o_q_bit
);

    logic [DIV_D_W:0] w_trial;
    logic             w_unused_msb;

    // The partial remainder's top bit falls off the shift; it only carries
    // information for inputs that overflow the quotient width.
    assign w_trial      = {i_rem[DIV_D_W-1:0], i_bit};
    assign w_unused_msb = i_rem[DIV_D_W];

    assign o_q_bit = (w_trial >= {1'b0, i_divisor});
    assign o_rem   = o_q_bit ? (w_trial - {1'b0, i_divisor}) : w_trial;

endmodule

`default_nettype wire

// File: rtl/hier_func_div_21ns_6ns_15_seq.sv
// ============================================================================
// Module   : hier_func_div_21ns_6ns_15_seq
// Brief    : 21/6 -> 15q,6r sequential restoring divider with valid/ready
//            and ce stall. HIER_FUNC_DIV_OVF_CHECK_EN enables overflow bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hier_func_div_21ns_6ns_15_seq
    import hier_func_div_pkg::*;
#(
    parameter int ID         = 32'd1,
    parameter int din0_WIDTH = 32'd21,
    parameter int din1_WIDTH = 32'd6,
    parameter int dout_WIDTH = 32'd15
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  din_vld,
    output logic                  din_rdy,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf
);

    localparam int c_unused_id = ID;

    div_state_t             r_state;
    div_state_t             w_state_next;
    logic [DIV_D_W:0]       r_part;
    logic [DIV_D_W:0]       w_part_next;
    logic [DIV_Q_W-1:0]     r_shift;
    logic [DIV_CNT_W-1:0]   r_cnt;
    logic [DIV_D_W-1:0]     r_div;
    logic [DIV_Q_W-1:0]     r_quot;
    logic [DIV_D_W-1:0]     r_rem;
    logic                   r_dout_vld;
    logic                   w_q_bit;
    logic                   w_last;

`ifdef HIER_FUNC_DIV_OVF_CHECK_EN
    logic w_ovf_in;
    logic r_ovf;
    assign w_ovf_in = (din0[DIV_N_W-1:DIV_Q_W] >= din1);
    assign ovf      = r_ovf;
`else
    assign ovf      = 1'b0;
`endif

    hier_func_div_step u_step (
        .i_rem     (r_part),
        .i_bit     (r_shift[DIV_Q_W-1]),
        .i_divisor (r_div),
        .o_rem     (w_part_next),
        .o_q_bit   (w_q_bit)
    );

    assign w_last   = (r_cnt == '0);
    assign din_rdy  = (r_state == IDLE);
    assign dout_vld = r_dout_vld;
    assign quot     = r_quot;
    assign rem      = r_rem;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (ce && din_vld) begin
`ifdef HIER_FUNC_DIV_OVF_CHECK_EN
                    w_state_next = w_ovf_in ? HOLD : CALC;
`else
                    w_state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (ce && w_last) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (ce && dout_rdy) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Dividend bits leave the top of r_shift while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_part     <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_div      <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dout_vld <= 1'b0;
`ifdef HIER_FUNC_DIV_OVF_CHECK_EN
            r_ovf      <= 1'b0;
`endif
        end else if (ce) begin
            case (r_state)
                IDLE: begin
                    if (din_vld) begin
                        r_part  <= {1'b0, din0[DIV_N_W-1:DIV_Q_W]};
                        r_shift <= din0[DIV_Q_W-1:0];
                        r_cnt   <= DIV_LAST_STEP;
                        r_div   <= din1;
`ifdef HIER_FUNC_DIV_OVF_CHECK_EN
                        if (w_ovf_in) begin
                            r_quot     <= DIV_Q_SAT;
                            r_rem      <= '0;
                            r_ovf      <= 1'b1;
                            r_dout_vld <= 1'b1;
                        end
`endif
                    end
                end
                CALC: begin
                    r_part  <= w_part_next;
                    r_shift <= {r_shift[DIV_Q_W-2:0], w_q_bit};
                    r_cnt   <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_quot     <= {r_shift[DIV_Q_W-2:0], w_q_bit};
                        r_rem      <= w_part_next[DIV_D_W-1:0];
                        r_dout_vld <= 1'b1;
`ifdef HIER_FUNC_DIV_OVF_CHECK_EN
                        r_ovf      <= 1'b0;
`endif
                    end
                end
                HOLD: begin
                    if (dout_rdy) begin
                        r_dout_vld <= 1'b0;
                    end
                end
                default: r_dout_vld <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire
